or5_request_arbiter: RTL and testbench
======================================

Name: or5_request_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource among five requesters, e.g. the shared pixel/accumulator path in the recognition datapath.
- Incoming requests pass through a per-input polarity (bubble) mask and are then OR-reduced into an any-request flag.
- A single grant is issued and held until the owner finishes, releases, or times out.
- Sits between the five requesting stages and the shared resource's enable/select lines.

Parameters:
- BubblesMask, 0, 5-bit; bit i=1 inverts Req[i] (active-low requester).
- MaxHold, 0, 8-bit; maximum grant length in cycles; 0 = unlimited.

Ports:
- GlobalClock  input  1  single clock; all state updates on its rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Req  input  5  raw request lines, bit i = requester i.
- Done  input  1  owner finished; single-cycle pulse, sampled only in BUSY.
- Grant  output  5  one-hot grant, registered.
- GrantValid  output  1  high while any Grant bit is set.
- GrantIndex  output  3  binary index of the granted requester (0..4); valid only when GrantValid=1.
- AnyRequest  output  1  registered OR of the masked requests.
- Timeout  output  1  one-cycle pulse when a grant is revoked by MaxHold.

Behaviour:
- Masked request: r[i] = Req[i] XOR BubblesMask[i]. AnyRequest <= |r every cycle.
- Reset (Reset=0, asynchronous) forces:
  - outputs: Grant=0, GrantValid=0, GrantIndex=0, AnyRequest=0, Timeout=0;
  - internal: ptr=0, holdcnt=0, state=IDLE.
  - If reset occurs mid-grant, the grant drops immediately; there is no completion.
- States: IDLE, BUSY, GAP.
- IDLE:
  - If |r, select the first set r[k] scanning k = ptr, ptr+1, …, wrapping 4→0.
  - Next edge: Grant=onehot(k), GrantIndex=k, GrantValid=1, holdcnt=1, state=BUSY.
  - Latency is 1 cycle from request sampled to Grant visible.
  - If no request, stay in IDLE with all grant outputs 0.
- BUSY (owner g):
  - Release conditions: Done=1, or r[g]=0, or (MaxHold≠0 and holdcnt==MaxHold).
  - On release, next edge: Grant=0, GrantValid=0, ptr=(g==4)?0:g+1, holdcnt=0, state=GAP.
  - Timeout=1 for that one cycle only when the release is caused by MaxHold alone, i.e. Done=0 and r[g]=1.
  - Otherwise holdcnt increments, saturating at 255.
  - Requests from other lines never pre-empt the owner.
- GAP:
  - One mandatory idle cycle with no grant, so the resource sees a clean handover.
  - Next edge goes to IDLE; arbitration resumes one cycle later, using the updated ptr.
- Simultaneous events:
  - Done together with r[g] dropping counts as a single release with no Timeout.
  - If the only requester is the previous owner, it is re-granted after GAP+IDLE.
  - Done outside BUSY is ignored.
- Grant is always zero or one-hot. GrantIndex retains its last value when GrantValid=0.
- Requests that glitch high for one cycle in IDLE are granted if sampled. Requesters must hold Req until granted.

Decomposition:
- Shared package holds:
  - state encoding constants: ST_IDLE=2'd0, ST_BUSY=2'd1, ST_GAP=2'd2;
  - NUM_REQ=5 and the index width of 3.
- One natural sub-module: rr_priority_pick5, a combinational circuit taking (r[4:0], ptr[2:0]) and producing (found, index[2:0]). It implements the rotated priority scan and is unit-testable on its own.
- Mask XOR, OR-reduce, FSM and hold counter live in the top module.

Test Plan:
- Reset then Req=5'b00100, Mask=0 → Grant=5'b00100, GrantIndex=2 one cycle later. After a Done pulse: Grant=0 for 2 cycles, ptr=3.
- Req=5'b11111 held, Done pulsed one cycle after each grant → grants rotate in order 0,1,2,3,4,0, with a 2-cycle gap between them.
- BubblesMask=5'b00001, Req=5'b00001 → r=0, AnyRequest=0, no grant. Req=5'b00000 → grant to index 0.
- MaxHold=4, Req=5'b00010 held, no Done → Grant high for exactly 4 cycles, then Timeout=1 pulse, then re-grant to index 1 after GAP+IDLE.
- Owner 3 drops Req[3] in BUSY while Req[4] is set → Grant clears next edge, Timeout=0, then index 4 granted 2 cycles later.
- Reset asserted mid-BUSY (owner 2) → Grant=0 and GrantValid=0 asynchronously. After release with Req=5'b00101: grant goes to index 0 (ptr restored to 0).

Source files
------------

// File: rtl/or5_request_arbiter_pkg.sv
// Shared constants and types for the five-way round-robin request arbiter.
package or5_request_arbiter_pkg;

  localparam int NUM_REQ = 5;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/or5_request_arbiter_if.sv
// Request/grant bundle between the five requesting stages and the arbiter.
interface or5_request_arbiter_if;
  import or5_request_arbiter_pkg::*;

  logic [NUM_REQ-1:0] Req;
  logic               Done;
  logic [NUM_REQ-1:0] Grant;
  logic               GrantValid;
  logic [IDX_W-1:0]   GrantIndex;
  logic               AnyRequest;
  logic               Timeout;

  // The requester side drives requests and the owner's completion pulse.
  modport master (
    output Req, Done,
    input  Grant, GrantValid, GrantIndex, AnyRequest, Timeout
  );

  modport slave (
    input  Req, Done,
    output Grant, GrantValid, GrantIndex, AnyRequest, Timeout
  );

endinterface

// File: rtl/or5_request_arbiter_pick.sv
// Rotated priority scan: first set request at or after ptr, wrapping 4 -> 0.
module rr_priority_pick5
  import or5_request_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] r,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   index
);

  logic [IDX_W:0] cand;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = {1'b0, ptr} + (IDX_W + 1)'(off);
      if (cand >= (IDX_W + 1)'(NUM_REQ)) cand = cand - (IDX_W + 1)'(NUM_REQ);
      if (!found && r[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        index = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/or5_request_arbiter.sv
// Round-robin arbiter for five requesters with polarity mask, hold limit
// and a mandatory one-cycle gap between grants.
module or5_request_arbiter
  import or5_request_arbiter_pkg::*;
#(
  parameter logic [NUM_REQ-1:0] BubblesMask = '0,
  parameter logic [7:0]         MaxHold     = 8'd0
) (
  input  logic                  GlobalClock,
  input  logic                  Reset,
  or5_request_arbiter_if.slave  bus
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [7:0]         holdcnt_q, holdcnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0]   grant_index_q, grant_index_d;
  logic               any_request_q, any_request_d;
  logic               timeout_q, timeout_d;

  logic [NUM_REQ-1:0] r;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               owner_req;
  logic               max_hit;

  assign r = bus.Req ^ BubblesMask;

  rr_priority_pick5 u_pick (
    .r     (r),
    .ptr   (ptr_q),
    .found (pick_found),
    .index (pick_idx)
  );

  assign owner_req = r[grant_index_q];
  assign max_hit   = (MaxHold != 8'd0) && (holdcnt_q == MaxHold);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    holdcnt_d     = holdcnt_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_index_d = grant_index_q;
    any_request_d = |r;
    timeout_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d       = NUM_REQ'(1) << pick_idx;
          grant_index_d = pick_idx;
          grant_valid_d = 1'b1;
          holdcnt_d     = 8'd1;
          state_d       = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (bus.Done || !owner_req || max_hit) begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
          ptr_d         = (grant_index_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_index_q + IDX_W'(1);
          holdcnt_d     = 8'd0;
          state_d       = ST_GAP;
          // Timeout flags only revocations the owner did not ask for.
          timeout_d     = max_hit && !bus.Done && owner_req;
        end else if (holdcnt_q != 8'hFF) begin
          holdcnt_d = holdcnt_q + 8'd1;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge GlobalClock or negedge Reset) begin
    if (!Reset) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      holdcnt_q     <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_index_q <= '0;
      any_request_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      holdcnt_q     <= holdcnt_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_index_q <= grant_index_d;
      any_request_q <= any_request_d;
      timeout_q     <= timeout_d;
    end
  end

  assign bus.Grant      = grant_q;
  assign bus.GrantValid = grant_valid_q;
  assign bus.GrantIndex = grant_index_q;
  assign bus.AnyRequest = any_request_q;
  assign bus.Timeout    = timeout_q;

endmodule

// File: tb/tb_or5_request_arbiter.sv
// Directed bench for or5_request_arbiter: plain, bubble-masked and hold-limited instances.
module tb_or5_request_arbiter;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  or5_request_arbiter_if bus_base ();
  or5_request_arbiter_if bus_mask ();
  or5_request_arbiter_if bus_hold ();

  or5_request_arbiter #(.BubblesMask(5'b00000), .MaxHold(8'd0)) u_base (
    .GlobalClock (clk),
    .Reset       (rst_n),
    .bus         (bus_base.slave)
  );

  or5_request_arbiter #(.BubblesMask(5'b00001), .MaxHold(8'd0)) u_mask (
    .GlobalClock (clk),
    .Reset       (rst_n),
    .bus         (bus_mask.slave)
  );

  or5_request_arbiter #(.BubblesMask(5'b00000), .MaxHold(8'd4)) u_hold (
    .GlobalClock (clk),
    .Reset       (rst_n),
    .bus         (bus_hold.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_base(input string tag, input logic [4:0] g, input logic v);
    check({tag, ".grant"}, 32'(bus_base.Grant), 32'(g));
    check({tag, ".valid"}, 32'(bus_base.GrantValid), 32'(v));
  endtask

  int rot_exp[5] = '{3, 4, 0, 1, 2};

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus_base.Req = '0; bus_base.Done = 1'b0;
    bus_mask.Req = '0; bus_mask.Done = 1'b0;
    bus_hold.Req = '0; bus_hold.Done = 1'b0;

    tick(); tick();
    check_base("reset", 5'b00000, 1'b0);
    check("reset.index", 32'(bus_base.GrantIndex), 0);
    check("reset.any",   32'(bus_base.AnyRequest), 0);
    check("reset.tmo",   32'(bus_base.Timeout), 0);
    rst_n = 1'b1;

    // Single requester 2, one-cycle latency, then Done together with Req drop.
    bus_base.Req = 5'b00100;
    tick();
    check_base("t1.grant", 5'b00100, 1'b1);
    check("t1.index", 32'(bus_base.GrantIndex), 2);
    check("t1.any",   32'(bus_base.AnyRequest), 1);
    bus_base.Done = 1'b1;
    bus_base.Req  = 5'b00000;
    tick();
    bus_base.Done = 1'b0;
    check_base("t1.gap", 5'b00000, 1'b0);
    check("t1.no_tmo", 32'(bus_base.Timeout), 0);
    bus_base.Req = 5'b11111;
    tick();
    check_base("t1.idle", 5'b00000, 1'b0);
    tick();

    // All requesting: rotation starts at ptr=3 left by the previous owner.
    for (int i = 0; i < 5; i++) begin
      check_base($sformatf("rot%0d", i), 5'(1 << rot_exp[i]), 1'b1);
      check($sformatf("rot%0d.index", i), 32'(bus_base.GrantIndex), 32'(rot_exp[i]));
      bus_base.Done = 1'b1;
      tick();
      bus_base.Done = 1'b0;
      check_base($sformatf("rot%0d.gap", i), 5'b00000, 1'b0);
      tick();
      check_base($sformatf("rot%0d.idle", i), 5'b00000, 1'b0);
      tick();
    end

    // Owner 3 drops its request while 4 is waiting.
    check_base("drop.own3", 5'b01000, 1'b1);
    bus_base.Req = 5'b10000;
    tick();
    check_base("drop.gap", 5'b00000, 1'b0);
    check("drop.no_tmo", 32'(bus_base.Timeout), 0);
    tick();
    check_base("drop.idle", 5'b00000, 1'b0);
    tick();
    check_base("drop.own4", 5'b10000, 1'b1);
    check("drop.index4", 32'(bus_base.GrantIndex), 4);
    bus_base.Done = 1'b1;
    bus_base.Req  = 5'b00100;
    tick();
    bus_base.Done = 1'b0;
    check_base("hold_idx.gap", 5'b00000, 1'b0);
    check("hold_idx.index", 32'(bus_base.GrantIndex), 4);

    // Done outside BUSY is ignored; requester 2 still granted after the gap.
    bus_base.Done = 1'b1;
    tick();
    bus_base.Done = 1'b0;
    tick();
    check_base("rst.own2", 5'b00100, 1'b1);
    check("rst.index2", 32'(bus_base.GrantIndex), 2);

    // Asynchronous reset mid-grant, then ptr restarts at 0.
    #2 rst_n = 1'b0;
    #1;
    check_base("rst.async", 5'b00000, 1'b0);
    tick();
    bus_base.Req = 5'b00101;
    rst_n = 1'b1;
    tick();
    check_base("rst.regrant", 5'b00001, 1'b1);
    check("rst.regrant.index", 32'(bus_base.GrantIndex), 0);
    bus_base.Req = 5'b00000;

    // Bubble mask on bit 0: raw high means idle, raw low means request.
    bus_mask.Req = 5'b00001;
    tick(); tick();
    check("mask.any_off",   32'(bus_mask.AnyRequest), 0);
    check("mask.no_grant",  32'(bus_mask.Grant), 0);
    bus_mask.Req = 5'b00000;
    tick();
    check("mask.grant",     32'(bus_mask.Grant), 32'h01);
    check("mask.index",     32'(bus_mask.GrantIndex), 0);
    check("mask.any_on",    32'(bus_mask.AnyRequest), 1);
    bus_mask.Req = 5'b00001;
    tick();
    check("mask.release",   32'(bus_mask.Grant), 0);
    check("mask.no_tmo",    32'(bus_mask.Timeout), 0);

    // MaxHold=4: grant lasts exactly four cycles, then Timeout pulse.
    bus_hold.Req = 5'b00010;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("hold.c%0d.grant", c), 32'(bus_hold.Grant), 32'h02);
      check($sformatf("hold.c%0d.tmo", c), 32'(bus_hold.Timeout), 0);
    end
    tick();
    check("hold.revoked", 32'(bus_hold.Grant), 0);
    check("hold.tmo_pulse", 32'(bus_hold.Timeout), 1);
    tick();
    check("hold.idle", 32'(bus_hold.Grant), 0);
    check("hold.tmo_end", 32'(bus_hold.Timeout), 0);
    tick();
    check("hold.regrant", 32'(bus_hold.Grant), 32'h02);
    check("hold.regrant.index", 32'(bus_hold.GrantIndex), 1);
    bus_hold.Req = 5'b00000;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
